// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Digit counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (clog2(ndig) < 1) ? 1 : clog2(ndig);
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple-carry slice made of full-adder cells.
module serial_adder_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out
);

  logic [DIGIT:0] w_c;

  always_comb begin
    w_c    = '0;
    s_d    = '0;
    w_c[0] = c_in;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s_d[i]   = a_d[i] ^ b_d[i] ^ w_c[i];
      w_c[i+1] = (a_d[i] & b_d[i]) | (w_c[i] & (a_d[i] ^ b_d[i]));
    end
    c_out = w_c[DIGIT];
  end

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial WIDTH-bit adder with valid/ready handshake on both sides.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CNTW = cnt_width(NDIG);
  localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_adder_n: DIGIT must divide WIDTH exactly");
  end

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [WIDTH-1:0] r_part, w_part_nxt;
  logic [WIDTH-1:0] r_sum, w_sum_nxt;
  logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_cout, w_cout_nxt;
  logic             r_in_ready, w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;

  logic [DIGIT-1:0] w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_part_shift;
  logic             w_accept;
  logic             w_finish;

  serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d   (r_a[DIGIT-1:0]),
    .b_d   (r_b[DIGIT-1:0]),
    .c_in  (r_carry),
    .s_d   (w_s),
    .c_out (w_c)
  );

  // New digits enter at the MSB end so the result is aligned after NDIG steps.
  if (NDIG == 1) begin : g_one_digit
    assign w_part_shift = w_s;
  end else begin : g_multi_digit
    assign w_part_shift = {w_s, r_part[WIDTH-1:DIGIT]};
  end

  assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;
  assign w_finish = (r_state == ST_RUN) && (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_part_nxt  = r_part;
    w_sum_nxt   = r_sum;
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    w_cout_nxt  = r_cout;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_carry_nxt = cin;
          w_cnt_nxt   = '0;
          w_part_nxt  = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_a_nxt     = r_a >> DIGIT;
        w_b_nxt     = r_b >> DIGIT;
        w_carry_nxt = w_c;
        w_part_nxt  = w_part_shift;
        w_cnt_nxt   = r_cnt + CNTW'(1);
        if (w_finish) begin
          w_sum_nxt   = w_part_shift;
          w_cout_nxt  = w_c;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_part      <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_part      <= w_part_nxt;
      r_sum       <= w_sum_nxt;
      r_cnt       <= w_cnt_nxt;
      r_carry     <= w_carry_nxt;
      r_cout      <= w_cout_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_sign_a, r_sign_b, r_ovf;
  logic w_ovf;

  // Overflow uses the operand signs captured at acceptance.
  assign w_ovf = (r_sign_a == r_sign_b) && (w_part_shift[WIDTH-1] != r_sign_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign_a <= a[WIDTH-1];
        r_sign_b <= b[WIDTH-1];
      end
      if (w_finish) r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n across several WIDTH/DIGIT configurations.
module tb_serial_adder_n;

  localparam int NC = 4;
  localparam int unsigned CWS [NC] = '{8, 8, 16, 32};
  localparam int unsigned CDS [NC] = '{1, 2, 4, 32};

  logic        clk;
  logic        rst;
  logic        in_valid_v  [NC];
  logic        in_ready_v  [NC];
  logic [31:0] a_v         [NC];
  logic [31:0] b_v         [NC];
  logic        cin_v       [NC];
  logic        out_valid_v [NC];
  logic        out_ready_v [NC];
  logic [31:0] sum_v       [NC];
  logic        cout_v      [NC];
  logic        ovf_v       [NC];

  int n_checks;
  int n_pass;

  logic [33:0] exp_q[$];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int unsigned W = CWS[g];
    localparam int unsigned D = CDS[g];
    logic [W-1:0] w_sum;
    logic         w_ir, w_ov, w_co, w_ovf;

    serial_adder_n #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (w_ir),
      .a         (a_v[g][W-1:0]),
      .b         (b_v[g][W-1:0]),
      .cin       (cin_v[g]),
      .out_valid (w_ov),
      .out_ready (out_ready_v[g]),
      .sum       (w_sum),
      .cout      (w_co)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (w_ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign w_ovf = 1'b0;
`endif
    assign in_ready_v[g]  = w_ir;
    assign out_valid_v[g] = w_ov;
    assign cout_v[g]      = w_co;
    assign sum_v[g]       = 32'(w_sum);
    assign ovf_v[g]       = w_ovf;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} of (a + b + cin) on w-bit operands.
  function automatic logic [33:0] ref_result(input int unsigned w, input logic [31:0] a,
                                             input logic [31:0] b, input logic cin);
    logic [63:0] mask, am, bm, s;
    logic        ov;
    mask = (64'd1 << w) - 64'd1;
    am   = 64'(a) & mask;
    bm   = 64'(b) & mask;
    s    = am + bm + 64'(cin);
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, s[w], 32'(s & mask)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input int c, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
    a_v[c]        = a;
    b_v[c]        = b;
    cin_v[c]      = cin;
    in_valid_v[c] = 1'b1;
    step();
    in_valid_v[c] = 1'b0;
  endtask

  task automatic release_result(input int c);
    out_ready_v[c] = 1'b1;
    step();
    out_ready_v[c] = 1'b0;
  endtask

  task automatic wait_valid(input int c);
    int n;
    n = 0;
    while (!out_valid_v[c] && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int c = 0; c < NC; c++) begin
      n_checks++;
      if ({in_ready_v[c], out_valid_v[c], cout_v[c], sum_v[c]} !== {1'b1, 1'b0, 1'b0, 32'd0})
        $display("FAIL reset cfg%0d: got rdy=%b vld=%b cout=%b sum=%h, want rdy=1 vld=0 cout=0 sum=0",
                 c, in_ready_v[c], out_valid_v[c], cout_v[c], sum_v[c]);
      else n_pass++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_carry_chain();
    n_checks++;
    if (in_ready_v[0] !== 1'b1) $display("FAIL chain_ready_idle: got %b want 1", in_ready_v[0]);
    else n_pass++;
    accept_op(0, 32'hFF, 32'h01, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      n_checks++;
      if (in_ready_v[0] !== 1'b0) $display("FAIL chain_ready_low c%0d: got %b want 0", i, in_ready_v[0]);
      else n_pass++;
      n_checks++;
      if (out_valid_v[0] !== (i == 8))
        $display("FAIL chain_latency c%0d: got out_valid=%b want %b", i, out_valid_v[0], (i == 8));
      else n_pass++;
    end
    n_checks++;
    if ({cout_v[0], sum_v[0]} !== {1'b1, 32'h00})
      $display("FAIL chain_result: got cout=%b sum=%h want cout=1 sum=00", cout_v[0], sum_v[0]);
    else n_pass++;
    release_result(0);
  endtask

  task automatic test_hold();
    accept_op(0, 32'hFF, 32'hFF, 1'b1);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b1, 32'hFF})
        $display("FAIL hold c%0d: got vld=%b cout=%b sum=%h want vld=1 cout=1 sum=ff",
                 i, out_valid_v[0], cout_v[0], sum_v[0]);
      else n_pass++;
      step();
    end
    release_result(0);
    n_checks++;
    if ({out_valid_v[0], in_ready_v[0]} !== 2'b01)
      $display("FAIL hold_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid_v[0], in_ready_v[0]);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int seen;
    accept_op(0, 32'h12, 32'h34, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid_v[0], in_ready_v[0], cout_v[0], sum_v[0]} !== {1'b0, 1'b1, 1'b0, 32'd0})
      $display("FAIL abort_reset: got vld=%b rdy=%b cout=%b sum=%h want vld=0 rdy=1 cout=0 sum=0",
               out_valid_v[0], in_ready_v[0], cout_v[0], sum_v[0]);
    else n_pass++;
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid_v[0]) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
    else n_pass++;
    accept_op(0, 32'h05, 32'h03, 1'b0);
    wait_valid(0);
    n_checks++;
    if ({out_valid_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b0, 32'h08})
      $display("FAIL abort_next_op: got vld=%b cout=%b sum=%h want vld=1 cout=0 sum=08",
               out_valid_v[0], cout_v[0], sum_v[0]);
    else n_pass++;
    release_result(0);
  endtask

  task automatic test_ignore_inputs();
    accept_op(0, 32'h5A, 32'h3C, 1'b1);
    for (int i = 0; i < 8; i++) begin
      in_valid_v[0] = 1'($urandom);
      a_v[0]        = $urandom;
      b_v[0]        = $urandom;
      cin_v[0]      = 1'($urandom);
      step();
    end
    in_valid_v[0] = 1'b0;
    wait_valid(0);
    n_checks++;
    if ({out_valid_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b0, 32'h97})
      $display("FAIL ignore_inputs: got vld=%b cout=%b sum=%h want vld=1 cout=0 sum=97",
               out_valid_v[0], cout_v[0], sum_v[0]);
    else n_pass++;
    release_result(0);
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    accept_op(0, 32'h7F, 32'h01, 1'b0);
    wait_valid(0);
    n_checks++;
    if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b0, 32'h80})
      $display("FAIL ovf_pos: got ovf=%b cout=%b sum=%h want ovf=1 cout=0 sum=80",
               ovf_v[0], cout_v[0], sum_v[0]);
    else n_pass++;
    release_result(0);
    accept_op(0, 32'h80, 32'h80, 1'b0);
    wait_valid(0);
    n_checks++;
    if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b1, 32'h00})
      $display("FAIL ovf_neg: got ovf=%b cout=%b sum=%h want ovf=1 cout=1 sum=00",
               ovf_v[0], cout_v[0], sum_v[0]);
    else n_pass++;
    release_result(0);
  endtask
`endif

  // Producer and consumer always willing: one result every NDIG+2 cycles.
  task automatic test_back_to_back();
    int last_acc, n_acc, prev_valid;
    logic [33:0] exp;
    last_acc   = -1;
    n_acc      = 0;
    prev_valid = 0;
    exp_q.delete();
    out_ready_v[0] = 1'b1;
    in_valid_v[0]  = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      a_v[0]   = $urandom;
      b_v[0]   = $urandom;
      cin_v[0] = 1'($urandom);
      if (out_valid_v[0]) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
        n_checks++;
        if ({cout_v[0], sum_v[0]} !== exp[32:0])
          $display("FAIL b2b_result: got cout=%b sum=%h want %h", cout_v[0], sum_v[0], exp[32:0]);
        else n_pass++;
        n_checks++;
        if (prev_valid !== 0) $display("FAIL b2b_done_one_cycle: out_valid high two cycles");
        else n_pass++;
      end
      prev_valid = int'(out_valid_v[0]);
      if (in_ready_v[0]) begin
        exp_q.push_back(ref_result(8, a_v[0], b_v[0], cin_v[0]));
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc !== 10) $display("FAIL b2b_interval: got %0d want 10", cyc - last_acc);
          else n_pass++;
        end
        last_acc = cyc;
        n_acc++;
      end
      step();
    end
    in_valid_v[0] = 1'b0;
    wait_valid(0);
    step();
    out_ready_v[0] = 1'b0;
    n_checks++;
    if (n_acc < 3) $display("FAIL b2b_accepts: got %0d want >=3", n_acc);
    else n_pass++;
  endtask

  task automatic test_random(input int c);
    logic [33:0] exp, got, cmask;
    int n_res;
`ifdef SERIAL_ADDER_OVF_EN
    cmask = {34{1'b1}};
`else
    cmask = {1'b0, {33{1'b1}}};
`endif
    exp_q.delete();
    n_res = 0;
    for (int cyc = 0; cyc < 1040; cyc++) begin
      if (cyc < 1000) begin
        in_valid_v[c]  = ($urandom_range(0, 9) < 6);
        out_ready_v[c] = ($urandom_range(0, 9) < 5);
      end else begin
        in_valid_v[c]  = 1'b0;
        out_ready_v[c] = 1'b1;
      end
      a_v[c]   = $urandom;
      b_v[c]   = $urandom;
      cin_v[c] = 1'($urandom);
      if (out_valid_v[c] && out_ready_v[c]) begin
        got = {ovf_v[c], cout_v[c], sum_v[c]};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
        n_res++;
        n_checks++;
        if ((got & cmask) !== (exp & cmask))
          $display("FAIL random cfg%0d res%0d: got %h want %h", c, n_res, got & cmask, exp & cmask);
        else n_pass++;
      end
      if (in_valid_v[c] && in_ready_v[c])
        exp_q.push_back(ref_result(CWS[c], a_v[c], b_v[c], cin_v[c]));
      step();
    end
    out_ready_v[c] = 1'b0;
    n_checks++;
    if (exp_q.size() !== 0 || n_res < 20)
      $display("FAIL random_drain cfg%0d: got pending=%0d results=%0d want pending=0 results>=20",
               c, exp_q.size(), n_res);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    for (int c = 0; c < NC; c++) begin
      in_valid_v[c]  = 1'b0;
      out_ready_v[c] = 1'b0;
      a_v[c]         = '0;
      b_v[c]         = '0;
      cin_v[c]       = 1'b0;
    end
    test_reset();
    test_carry_chain();
    test_hold();
    test_reset_abort();
    test_ignore_inputs();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    for (int c = 0; c < NC; c++) test_random(c);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
